// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: datapath width, reset PC default, NOP encoding
// and the {pc, inst} entry layout buffered between imem and decode.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO for fetched instructions; flush wins over push and pop, and
// the head output keeps showing the last presented entry while empty.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH):0]       count,
  output logic [WIDTH-1:0]             head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] last_head;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !flush && (count != '0);
  assign do_push = push && !flush && ((count != CW'(DEPTH)) || do_pop);
  assign head    = (count != '0) ? mem[rd_ptr] : last_head;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Remember what the consumer last saw so the outputs hold steady when empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_head <= '0;
    end else if (count != '0) begin
      last_head <= mem[rd_ptr];
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && (count == CW'(DEPTH))));

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: credit-limited sequential imem fetches feeding a
// small FIFO toward decode, with epoch-tagged flush on core redirect.
module if_prefetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(fetch_pkg::DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_rvalid,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   req_pc;
  logic              inflight;
  logic              req_epoch;
  logic              epoch;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] head;
  logic              push;
  logic              pop;
  logic              credit_ok;
  logic              unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Buffered plus outstanding entries may never exceed the FIFO capacity.
  assign credit_ok  = (count + CW'(inflight)) < CW'(DEPTH);
  assign imem_req   = rst_n && !redirect && credit_ok;
  assign imem_addr  = fetch_pc;
  assign push       = imem_rvalid && inflight && (req_epoch == epoch);
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign {inst_pc, inst} = head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      inflight  <= 1'b0;
      req_pc    <= '0;
      req_epoch <= 1'b0;
      epoch     <= 1'b0;
    end else begin
      if (redirect) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        epoch    <= ~epoch;
      end else if (imem_req) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (imem_req) begin
        inflight  <= 1'b1;
        req_pc    <= fetch_pc;
        req_epoch <= epoch;
      end else if (imem_rvalid) begin
        inflight <= 1'b0;
      end
    end
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({req_pc, imem_rdata}),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

endmodule
